// File: rtl/exp1_6c_pkg.sv
// Shared definitions for exp1_6c: step encoding, default step length and the 8-bit add helper.
// Optional macro EXP1_6C_SAT_EN makes the add helper saturate at 255 instead of wrapping.
package exp1_6c_pkg;

  typedef enum logic [1:0] {
    STEP0 = 2'd0,
    STEP1 = 2'd1,
    STEP2 = 2'd2,
    STEP3 = 2'd3
  } step_e;

  localparam int STEP_LEN_DEF = 10;

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {1'b0, b};
`ifdef EXP1_6C_SAT_EN
    if (sum[8]) begin
      add8 = 8'hFF;
    end else begin
      add8 = sum[7:0];
    end
`else
    add8 = sum[7:0];
`endif
  endfunction

endpackage

// File: rtl/exp1_6c_step_timer.sv
// Step timer: owns the in-step cycle counter and the step index, and flags the last cycle of each step.
module exp1_6c_step_timer
  import exp1_6c_pkg::*;
#(
  parameter int STEP_LEN = STEP_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] o_c1,
  output step_e      o_step,
  output logic       o_last
);

  localparam logic [7:0] LAST_C = 8'(STEP_LEN - 1);

  logic [7:0] r_c1;
  step_e      r_step;
  logic [7:0] w_c1_nxt;
  step_e      w_step_nxt;
  logic       w_last;

  // Next-state logic for the counter and the step index
  always_comb begin
    w_last     = (r_c1 == LAST_C);
    w_c1_nxt   = r_c1;
    w_step_nxt = r_step;
    if (w_last) begin
      w_c1_nxt = 8'd0;
      case (r_step)
        STEP0:   w_step_nxt = STEP1;
        STEP1:   w_step_nxt = STEP2;
        STEP2:   w_step_nxt = STEP3;
        STEP3:   w_step_nxt = STEP0;
        default: w_step_nxt = STEP0;
      endcase
    end else begin
      w_c1_nxt   = r_c1 + 8'd1;
      w_step_nxt = r_step;
    end
  end

  // State register for counter and step index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c1   <= 8'd0;
      r_step <= STEP0;
    end else begin
      r_c1   <= w_c1_nxt;
      r_step <= w_step_nxt;
    end
  end

  assign o_c1   = r_c1;
  assign o_step = r_step;
  assign o_last = w_last;

endmodule

// File: rtl/exp1_6c.sv
// exp1_6c top: four-step round sequencer updating x, y, act1, act2 on each step's last cycle.
// Optional macro EXP1_6C_SAT_EN selects saturating arithmetic for the x, y and act1 updates.
module exp1_6c
  import exp1_6c_pkg::*;
#(
  parameter int STEP_LEN = STEP_LEN_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] c1,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic [7:0] act1,
  output logic [7:0] act2,
  output logic [1:0] i
);

  logic [7:0] w_c1;
  step_e      w_step;
  logic       w_last;

  logic [7:0] r_x, r_y, r_act1, r_act2;
  logic [7:0] w_x_nxt, w_y_nxt, w_act1_nxt, w_act2_nxt;

  exp1_6c_step_timer #(
    .STEP_LEN (STEP_LEN)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_c1   (w_c1),
    .o_step (w_step),
    .o_last (w_last)
  );

  // Data-path next values: only the current step's register moves, and only on its last cycle
  always_comb begin
    w_x_nxt    = r_x;
    w_y_nxt    = r_y;
    w_act1_nxt = r_act1;
    w_act2_nxt = r_act2;
    if (w_last) begin
      case (w_step)
        STEP0:   w_x_nxt    = add8(r_x, 8'd1);
        STEP1:   w_y_nxt    = add8(r_y, r_x);
        STEP2:   w_act1_nxt = add8(r_x, r_y);
        STEP3:   w_act2_nxt = r_act1 ^ r_y;
        default: w_x_nxt    = r_x;
      endcase
    end else begin
      w_x_nxt    = r_x;
      w_y_nxt    = r_y;
      w_act1_nxt = r_act1;
      w_act2_nxt = r_act2;
    end
  end

  // Data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= 8'd0;
      r_y    <= 8'd0;
      r_act1 <= 8'd0;
      r_act2 <= 8'd0;
    end else begin
      r_x    <= w_x_nxt;
      r_y    <= w_y_nxt;
      r_act1 <= w_act1_nxt;
      r_act2 <= w_act2_nxt;
    end
  end

  assign c1   = w_c1;
  assign i    = w_step;
  assign x    = r_x;
  assign y    = r_y;
  assign act1 = r_act1;
  assign act2 = r_act2;

endmodule

// File: tb/tb_exp1_6c.sv
// Directed bench for exp1_6c with STEP_LEN=10: vector table over two rounds, async reset cases, 256-round run.
module tb_exp1_6c;

  logic       clk;
  logic       rst_n;
  logic [7:0] c1, x, y, act1, act2;
  logic [1:0] i;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_n;
    logic [7:0] c1;
    logic [1:0] i;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] a1;
    logic [7:0] a2;
  } vec_t;

  vec_t vecs[15];

  exp1_6c #(.STEP_LEN(10)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .c1   (c1),
    .x    (x),
    .y    (y),
    .act1 (act1),
    .act2 (act2),
    .i    (i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s edge=%0d got %0d expected %0d", name, edge_cnt, got, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_c1, input logic [1:0] e_i,
                         input logic [7:0] e_x, input logic [7:0] e_y,
                         input logic [7:0] e_a1, input logic [7:0] e_a2);
    chk({tag, ".c1"},   c1,        e_c1);
    chk({tag, ".i"},    {6'd0, i}, {6'd0, e_i});
    chk({tag, ".x"},    x,         e_x);
    chk({tag, ".y"},    y,         e_y);
    chk({tag, ".act1"}, act1,      e_a1);
    chk({tag, ".act2"}, act2,      e_a2);
  endtask

  task automatic run_table(input string tag);
    for (int k = 0; k < 15; k++) begin
      while (edge_cnt < vecs[k].edge_n) tick();
      chk_all($sformatf("%s_e%0d", tag, vecs[k].edge_n), vecs[k].c1, vecs[k].i,
              vecs[k].x, vecs[k].y, vecs[k].a1, vecs[k].a2);
    end
  endtask

  function automatic logic [7:0] m_add(input logic [7:0] a, input logic [7:0] b);
    int s;
    s = int'(a) + int'(b);
`ifdef EXP1_6C_SAT_EN
    if (s > 255) s = 255;
`endif
    return 8'(s);
  endfunction

  initial begin
    logic [7:0] mx, my, ma1, ma2;

    //         edge  c1     i     x     y     act1  act2
    vecs[0]  = '{0,  8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[1]  = '{1,  8'd1, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[2]  = '{9,  8'd9, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[3]  = '{10, 8'd0, 2'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    vecs[4]  = '{15, 8'd5, 2'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    vecs[5]  = '{20, 8'd0, 2'd2, 8'd1, 8'd1, 8'd0, 8'd0};
    vecs[6]  = '{30, 8'd0, 2'd3, 8'd1, 8'd1, 8'd2, 8'd0};
    vecs[7]  = '{39, 8'd9, 2'd3, 8'd1, 8'd1, 8'd2, 8'd0};
    vecs[8]  = '{40, 8'd0, 2'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    vecs[9]  = '{45, 8'd5, 2'd0, 8'd1, 8'd1, 8'd2, 8'd3};
    vecs[10] = '{50, 8'd0, 2'd1, 8'd2, 8'd1, 8'd2, 8'd3};
    vecs[11] = '{60, 8'd0, 2'd2, 8'd2, 8'd3, 8'd2, 8'd3};
    vecs[12] = '{70, 8'd0, 2'd3, 8'd2, 8'd3, 8'd5, 8'd3};
    vecs[13] = '{80, 8'd0, 2'd0, 8'd2, 8'd3, 8'd5, 8'd6};
    vecs[14] = '{85, 8'd5, 2'd0, 8'd2, 8'd3, 8'd5, 8'd6};

    // Reset held across 100 clock edges
    rst_n = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk_all("rst_hold", 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    run_table("r1");

    // Advance into round 3 to step 2, c1=5 (edge 105)
    while (edge_cnt < 105) tick();
    chk_all("pre_mid_rst", 8'd5, 2'd2, 8'd3, 8'd6, 8'd5, 8'd6);

    // Async reset between edges: outputs must clear with no clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("mid_rst", 8'd0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);

    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    run_table("r2");

    // Fresh start, then 256 full rounds against a small reference model
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst3.x", x, 8'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    edge_cnt = 0;
    repeat (256 * 40) tick();

    mx = 8'd0; my = 8'd0; ma1 = 8'd0; ma2 = 8'd0;
    for (int r = 0; r < 256; r++) begin
      mx  = m_add(mx, 8'd1);
      my  = m_add(my, mx);
      ma1 = m_add(mx, my);
      ma2 = ma1 ^ my;
    end
    chk_all("r256", 8'd0, 2'd0, mx, my, ma1, ma2);
`ifdef EXP1_6C_SAT_EN
    chk("sat.y", y, 8'd255);
    chk("sat.act1", act1, 8'd255);
    chk("sat.act2", act2, 8'd0);
`else
    chk("wrap.x", x, 8'd0);
    chk("wrap.y", y, 8'd128);
    chk("wrap.act1", act1, 8'd128);
    chk("wrap.act2", act2, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exp1_6c.md
EXP1_6C -- requirements
Module: exp1_6c

Interface
REQ-001 Parameter STEP_LEN, default 10, cycles spent in each step; legal range 2..256.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 c1  output  8  cycle counter within the current step, 0..STEP_LEN-1.
REQ-005 x  output  8  round counter, updated in step 0.
REQ-006 y  output  8  accumulator, updated in step 1.
REQ-007 act1  output  8  sum result, updated in step 2.
REQ-008 act2  output  8  xor result, updated in step 3.
REQ-009 i  output  2  current step index, 0..3.

Function
REQ-010 All outputs SHALL be registered; no combinational paths from inputs to outputs.
REQ-011 c1 SHALL increment by 1 each clock; when c1==STEP_LEN-1 ("LAST"), c1 SHALL return to 0 and i SHALL advance by 1, wrapping 3->0.
REQ-012 On the LAST cycle of step 0, x SHALL become x+1.
REQ-013 On the LAST cycle of step 1, y SHALL become y+x.
REQ-014 On the LAST cycle of step 2, act1 SHALL become x+y.
REQ-015 On the LAST cycle of step 3, act2 SHALL become act1 XOR y.
REQ-016 Each of x, y, act1, act2 SHALL change only on its step's LAST cycle and hold otherwise.
REQ-017 Each operation SHALL use register values present before that clock edge; results are visible one edge later (latency 1).
REQ-018 Arithmetic SHALL be 8-bit, carries discarded (mod 256) unless REQ-024 applies.
REQ-019 With STEP_LEN=256, c1 SHALL run the full 0..255 range and wrap to 0 at step change.
REQ-020 A full round SHALL take exactly 4*STEP_LEN clocks; the sequence SHALL run continuously with no stall.

Reset
REQ-021 rst_n low SHALL immediately force c1, i, x, y, act1, act2 to 0, independent of clk.
REQ-022 Reset asserted mid-step or mid-round SHALL discard all progress; no partial update SHALL survive.
REQ-023 After release, the first rising edge SHALL give c1=1, i=0; the first x update occurs on the STEP_LEN-th edge.

Configuration
REQ-024 Macro EXP1_6C_SAT_EN defined: the x increment, y add and act1 add SHALL saturate at 255 instead of wrapping; XOR is unaffected.
REQ-025 Macro EXP1_6C_SAT_EN undefined: all arithmetic SHALL wrap mod 256 per REQ-018.

Structure
REQ-026 Package exp1_6c_pkg SHALL hold the step encoding (STEP0..STEP3 = 0..3), the default STEP_LEN constant and the 8-bit add helper (wrap or saturate).
REQ-027 Sub-module exp1_6c_step_timer SHALL own c1 and i and provide a LAST strobe; the top SHALL hold the data registers x, y, act1, act2.

Verification
REQ-028 Reset check: hold rst_n=0 for 100 clocks -> all outputs 0; drop rst_n mid-cycle with no clock edge -> outputs clear at once.
REQ-029 Timing, STEP_LEN=10: after release, edges 10/20/30/40 -> x=1, y=1, act1=2, act2=3, with i going 1,2,3,0 and c1=0 at each.
REQ-030 Second round, STEP_LEN=10: edges 50/60/70/80 -> x=2, y=3, act1=5, act2=6; between those edges the values hold.
REQ-031 Wrap, default build: run 256 rounds -> x returns to 0; y and act1 follow mod-256 arithmetic.
REQ-032 Saturation with EXP1_6C_SAT_EN: run until y would exceed 255 -> y holds 255; act1 holds 255; act2 equals act1 XOR y.
REQ-033 Mid-operation reset: assert rst_n=0 at i=2, c1=5 -> all zero; after release the sequence repeats REQ-029 exactly.
